// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Brief    : Frame geometry shared by the I2S capture and DAC transmit stages.
// Revision : 1.0
// ============================================================================
package audio_pkg;
    localparam int   SAMPLE_W   = 24;
    localparam int   FRAME_MCLK = 256;
    localparam int   SCLK_DIV   = 4;
    localparam int   SLOT_BITS  = 32;
    localparam logic LEFT_LRCK  = 1'b0;

    localparam int CNT_W = $clog2(FRAME_MCLK);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int POS_W = $clog2(SLOT_BITS);
endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clkgen
// Brief    : Frame counter deriving LRCK, SCLK, bit position and frame strobes.
// Revision : 1.0
// ============================================================================
module i2s_clkgen
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             lrck,
    output logic             sclk,
    output logic             load,
    output logic             upd,
    output logic             lrck_nxt,
    output logic [POS_W-1:0] bit_pos
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nxt;
    end

    assign lrck     = r_cnt[CNT_W-1];
    assign sclk     = r_cnt[DIV_W-1];
    assign load     = &r_cnt;
    // Update strobe fires on the last MCLK of an SCLK period, so the output
    // register presents the slot/position of the counter value that follows.
    assign upd      = &r_cnt[DIV_W-1:0];
    assign lrck_nxt = w_cnt_nxt[CNT_W-1];
    assign bit_pos  = w_cnt_nxt[CNT_W-2 -: POS_W];
endmodule
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_dac_tx
// Brief    : I2S transmitter for the CS4344 with holding buffer and frame shadow.
// Revision : 1.0
// ============================================================================
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DW     = SAMPLE_W,
    parameter int UCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_dataL,
    input  logic [DW-1:0]     in_dataR,
    input  logic              mute,
    output logic              mclk_dac,
    output logic              lrck_dac,
    output logic              sclk_dac,
    output logic              sdin_dac,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);
    logic             w_load;
    logic             w_upd;
    logic             w_lrck_nxt;
    logic [POS_W-1:0] w_pos;

    i2s_clkgen u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .lrck     (lrck_dac),
        .sclk     (sclk_dac),
        .load     (w_load),
        .upd      (w_upd),
        .lrck_nxt (w_lrck_nxt),
        .bit_pos  (w_pos)
    );

    assign mclk_dac = clk;

    logic [DW-1:0]     r_hold_l, r_hold_r, r_sh_l, r_sh_r;
    logic              r_hold_full;
    logic              r_under;
    logic              r_sdin;
    logic [UCNT_W-1:0] r_ucnt;
    logic              w_xfer;

    assign in_ready = ~r_hold_full | w_load;
    assign w_xfer   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_sh_l      <= '0;
            r_sh_r      <= '0;
            r_under     <= 1'b0;
            r_ucnt      <= '0;
        end else begin
            r_under <= 1'b0;
            if (w_load) begin
                if (mute) begin
                    r_sh_l <= '0;
                    r_sh_r <= '0;
                end else if (r_hold_full) begin
                    r_sh_l <= r_hold_l;
                    r_sh_r <= r_hold_r;
                end else begin
                    // Empty buffer: repeat the previous pair rather than glitch.
                    r_under <= 1'b1;
                    if (~&r_ucnt) r_ucnt <= r_ucnt + UCNT_W'(1);
                end
            end
            if (w_xfer) begin
                r_hold_l    <= in_dataL;
                r_hold_r    <= in_dataR;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    logic [DW-1:0]    w_word;
    logic [DW-1:0]    w_shift;
    logic [POS_W-1:0] w_idx;
    logic             w_bit;

    assign w_word  = (w_lrck_nxt == LEFT_LRCK) ? r_sh_l : r_sh_r;
    assign w_idx   = POS_W'(DW) - w_pos;
    assign w_shift = w_word >> w_idx;
    // Position 0 is the I2S one-bit delay; positions past DW pad with zeros.
    assign w_bit   = (w_pos != '0) && (w_pos <= POS_W'(DW)) ? w_shift[0] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_sdin <= 1'b0;
        else if (w_upd) r_sdin <= w_bit;
    end

    assign sdin_dac     = r_sdin;
    assign underrun     = r_under;
    assign underrun_cnt = r_ucnt;
endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_dac_tx
// Brief    : Scoreboard bench for the I2S DAC transmitter.
// Revision : 1.0
// ============================================================================
module tb_i2s_dac_tx;
    localparam int DW = 24;
    localparam int UW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          mute = 1'b0;
    logic [DW-1:0] in_dataL = '0;
    logic [DW-1:0] in_dataR = '0;
    logic          in_ready, mclk_dac, lrck_dac, sclk_dac, sdin_dac, underrun;
    logic [UW-1:0] underrun_cnt;

    i2s_dac_tx #(.DW(DW), .UCNT_W(UW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dataL     (in_dataL),
        .in_dataR     (in_dataR),
        .mute         (mute),
        .mclk_dac     (mclk_dac),
        .lrck_dac     (lrck_dac),
        .sclk_dac     (sclk_dac),
        .sdin_dac     (sdin_dac),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame counter, shadow pair, queue of accepted pairs.
    int              m_cnt = 0;
    logic [DW-1:0]   m_sh_l = '0, m_sh_r = '0;
    logic [2*DW-1:0] q[$];
    logic            m_under = 1'b0;
    int              m_ucnt = 0;

    initial forever begin
        int            k;
        logic [DW-1:0] word;
        logic          exp_sd, exp_rdy;
        logic [2*DW-1:0] p;
        @(negedge clk);
        if (rst) begin
            m_cnt = 0; m_sh_l = '0; m_sh_r = '0; q.delete(); m_under = 1'b0; m_ucnt = 0;
        end
        k       = (m_cnt >> 2) % 32;
        word    = (m_cnt >= 128) ? m_sh_r : m_sh_l;
        exp_sd  = (k >= 1 && k <= DW) ? word[DW-k] : 1'b0;
        exp_rdy = (q.size() == 0) || (m_cnt == 255);
        checks += 7;
        if (lrck_dac !== (m_cnt >= 128)) begin errors++; $display("FAIL mon_lrck cnt=%0d got %b exp %b", m_cnt, lrck_dac, m_cnt >= 128); end
        if (sclk_dac !== m_cnt[1]) begin errors++; $display("FAIL mon_sclk cnt=%0d got %b exp %b", m_cnt, sclk_dac, m_cnt[1]); end
        if (sdin_dac !== exp_sd) begin errors++; $display("FAIL mon_sdin cnt=%0d got %b exp %b", m_cnt, sdin_dac, exp_sd); end
        if (underrun !== m_under) begin errors++; $display("FAIL mon_underrun cnt=%0d got %b exp %b", m_cnt, underrun, m_under); end
        if (underrun_cnt !== m_ucnt[UW-1:0]) begin errors++; $display("FAIL mon_ucnt cnt=%0d got %0d exp %0d", m_cnt, underrun_cnt, m_ucnt); end
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL mon_ready cnt=%0d got %b exp %b", m_cnt, in_ready, exp_rdy); end
        if (mclk_dac !== 1'b0) begin errors++; $display("FAIL mon_mclk got %b exp 0", mclk_dac); end
        if (!rst) begin
            m_under = 1'b0;
            if (m_cnt == 255) begin
                if (mute) begin
                    if (q.size() > 0) p = q.pop_front();
                    m_sh_l = '0; m_sh_r = '0;
                end else if (q.size() > 0) begin
                    p = q.pop_front();
                    m_sh_l = p[2*DW-1:DW]; m_sh_r = p[DW-1:0];
                end else begin
                    m_under = 1'b1;
                    if (m_ucnt < (1 << UW) - 1) m_ucnt++;
                end
            end
            if (in_valid && exp_rdy) q.push_back({in_dataL, in_dataR});
            m_cnt = (m_cnt + 1) % 256;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        tick();
        while (m_cnt != v && n < 600) begin tick(); n++; end
        checks++;
        if (m_cnt != v) begin errors++; $display("FAIL wait_cnt timeout got %0d exp %0d", m_cnt, v); end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; in_valid = 1'b0; mute = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        in_valid = 1'b1; in_dataL = l; in_dataR = r;
        tick();
        in_valid = 1'b0; in_dataL = DW'($urandom); in_dataR = DW'($urandom);
    endtask

    task automatic capture_frame(output logic [31:0] l, output logic [31:0] r);
        int k;
        l = '0; r = '0;
        for (int i = 0; i < 256; i++) begin
            if (m_cnt % 4 == 1) begin
                k = (m_cnt / 4) % 32;
                if (m_cnt < 128) l[31-k] = sdin_dac;
                else             r[31-k] = sdin_dac;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] l, r;
        wait_cnt(0);
        wait_cnt(10);
        send_pair(24'h111111, 24'h222222);
        wait_cnt(77);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        checks += 5;
        if (sdin_dac !== 1'b0) begin errors++; $display("FAIL rst_sdin got %b exp 0", sdin_dac); end
        if (lrck_dac !== 1'b0) begin errors++; $display("FAIL rst_lrck got %b exp 0", lrck_dac); end
        if (sclk_dac !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", sclk_dac); end
        if (underrun_cnt !== 4'd0) begin errors++; $display("FAIL rst_ucnt got %0d exp 0", underrun_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
        tick(); tick();
        checks++;
        if (sclk_dac !== 1'b1) begin errors++; $display("FAIL rst_restart_sclk got %b exp 1", sclk_dac); end
        wait_cnt(0);
        checks += 2;
        if (underrun !== 1'b1) begin errors++; $display("FAIL rst_hold_discard got %b exp 1", underrun); end
        if (underrun_cnt !== 4'd1) begin errors++; $display("FAIL rst_ucnt1 got %0d exp 1", underrun_cnt); end
        capture_frame(l, r);
        checks++;
        if ({l, r} !== 64'd0) begin errors++; $display("FAIL rst_zero_frame got %h exp 0", {l, r}); end
    endtask

    task automatic test_single_pair();
        logic [31:0] l, r;
        do_reset();
        wait_cnt(10);
        send_pair(24'hA5A5A5, 24'h5A5A5A);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL pair_ready11 got %b exp 0", in_ready); end
        wait_cnt(254);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL pair_ready254 got %b exp 0", in_ready); end
        wait_cnt(255);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pair_ready255 got %b exp 1", in_ready); end
        tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL pair_no_underrun got %b exp 0", underrun); end
        capture_frame(l, r);
        checks += 2;
        if (l !== {1'b0, 24'hA5A5A5, 7'd0}) begin errors++; $display("FAIL pair_left got %h exp %h", l, {1'b0, 24'hA5A5A5, 7'd0}); end
        if (r !== {1'b0, 24'h5A5A5A, 7'd0}) begin errors++; $display("FAIL pair_right got %h exp %h", r, {1'b0, 24'h5A5A5A, 7'd0}); end
    endtask

    task automatic test_underrun();
        logic [31:0] l, r;
        do_reset();
        wait_cnt(10);
        send_pair(24'h800001, 24'h7FFFFE);
        wait_cnt(0);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_frame1 got %b exp 0", underrun); end
        capture_frame(l, r);
        checks += 2;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_frame2_pulse got %b exp 1", underrun); end
        if (underrun_cnt !== 4'd1) begin errors++; $display("FAIL ur_cnt1 got %0d exp 1", underrun_cnt); end
        capture_frame(l, r);
        checks += 2;
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_frame3_pulse got %b exp 1", underrun); end
        if (underrun_cnt !== 4'd2) begin errors++; $display("FAIL ur_cnt2 got %0d exp 2", underrun_cnt); end
        tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_pulse_width got %b exp 0", underrun); end
        wait_cnt(0);
        capture_frame(l, r);
        checks += 2;
        if (l !== {1'b0, 24'h800001, 7'd0}) begin errors++; $display("FAIL ur_repeat_left got %h exp %h", l, {1'b0, 24'h800001, 7'd0}); end
        if (r !== {1'b0, 24'h7FFFFE, 7'd0}) begin errors++; $display("FAIL ur_repeat_right got %h exp %h", r, {1'b0, 24'h7FFFFE, 7'd0}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] l, r;
        do_reset();
        wait_cnt(10);
        send_pair(24'hFFFFFF, 24'h000001);
        wait_cnt(200);
        in_valid = 1'b1; in_dataL = 24'h123456; in_dataR = 24'h654321;
        for (int c = 200; c < 255; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall cnt=%0d got %b exp 0", c, in_ready); end
            tick();
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept255 got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_ur1 got %b exp 0", underrun); end
        capture_frame(l, r);
        checks += 3;
        if (l !== {1'b0, 24'hFFFFFF, 7'd0}) begin errors++; $display("FAIL b2b_old_left got %h exp %h", l, {1'b0, 24'hFFFFFF, 7'd0}); end
        if (r !== {1'b0, 24'h000001, 7'd0}) begin errors++; $display("FAIL b2b_old_right got %h exp %h", r, {1'b0, 24'h000001, 7'd0}); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_ur2 got %b exp 0", underrun); end
        capture_frame(l, r);
        checks += 3;
        if (l !== {1'b0, 24'h123456, 7'd0}) begin errors++; $display("FAIL b2b_new_left got %h exp %h", l, {1'b0, 24'h123456, 7'd0}); end
        if (r !== {1'b0, 24'h654321, 7'd0}) begin errors++; $display("FAIL b2b_new_right got %h exp %h", r, {1'b0, 24'h654321, 7'd0}); end
        if (underrun_cnt !== 4'd1) begin errors++; $display("FAIL b2b_ucnt got %0d exp 1", underrun_cnt); end
    endtask

    task automatic test_mute();
        logic [31:0] l, r;
        do_reset();
        wait_cnt(10);
        send_pair(24'h0F0F0F, 24'hF0F0F0);
        wait_cnt(10);
        send_pair(24'h333333, 24'hCCCCCC);
        wait_cnt(250);
        mute = 1'b1;
        wait_cnt(0);
        mute = 1'b0;
        checks += 2;
        if (underrun !== 1'b0) begin errors++; $display("FAIL mute_no_underrun got %b exp 0", underrun); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mute_hold_empty got %b exp 1", in_ready); end
        capture_frame(l, r);
        checks += 2;
        if ({l, r} !== 64'd0) begin errors++; $display("FAIL mute_zero_frame got %h exp 0", {l, r}); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL mute_then_empty got %b exp 1", underrun); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < (1 << UW) + 5; f++) wait_cnt(0);
        checks += 2;
        if (underrun_cnt !== 4'hF) begin errors++; $display("FAIL sat_ucnt got %h exp F", underrun_cnt); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL sat_pulse got %b exp 1", underrun); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_mute();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Downstream partner of the CS5343 capture stage: serialises 24-bit stereo sample pairs into the I2S stream for the CS4344 DAC.
- Generates MCLK, LRCK and SCLK from clk, with the same frame geometry as the capture side: 256 MCLK per frame, 64 SCLK per frame.
- Accepts samples via a valid/ready handshake into a one-entry holding buffer. A frame shadow register keeps the bit stream stable while upstream writes the next pair.

Parameters:
- DW, 24, sample width; legal range 1..31.
- UCNT_W, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  master clock (12.288 MHz typ); forwarded as mclk_dac.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding buffer can accept.
- in_dataL  in  DW  left sample, two's complement.
- in_dataR  in  DW  right sample, two's complement.
- mute  in  1  when 1, frames load zeros instead of buffered data.
- mclk_dac  out  1  = clk.
- lrck_dac  out  1  0 = left slot, 1 = right slot.
- sclk_dac  out  1  bit clock = clk/4.
- sdin_dac  out  1  serial data to DAC.
- underrun  out  1  one-clk pulse when a frame starts with the buffer empty.
- underrun_cnt  out  UCNT_W  saturating count of underruns.

Behaviour:
- Reset (async, rst=1): cnt=0, hold empty, shadow L/R=0, sdin_dac=0, underrun=0, underrun_cnt=0. in_ready=1 as soon as rst deasserts.
- cnt[7:0] free-running, +1 per clk, wraps 255->0.
- lrck_dac=cnt[7]: cnt 0..127 is the left slot, 128..255 the right slot.
- sclk_dac=cnt[1]: low for cnt[1:0]=0,1, high for 2,3. Data changes while SCLK is low; the DAC samples on SCLK rising.
- Slot bit position k=cnt[6:2] (0..31), word = cnt[7] ? shadowR : shadowL.
- sdin_dac is registered and updated so that while cnt holds a value with position k:
  - k=0: sdin_dac=0 (I2S one-bit delay).
  - 1<=k<=DW: sdin_dac=word[DW-k], MSB first.
  - k>DW: sdin_dac=0.
- Frame load happens on the clk edge where cnt goes 255->0 (load_now = cnt==255):
  - mute=1: shadow<=0. Hold is consumed if full; no underrun is flagged.
  - hold full: shadow<=hold, hold becomes empty.
  - hold empty, mute=0: shadow keeps its previous pair; underrun=1 for that cycle; underrun_cnt increments, saturating at all-ones.
- Handshake:
  - in_ready = ~hold_full | load_now (combinational).
  - A transfer occurs when in_valid & in_ready; hold<=in_data and hold becomes full.
  - When load_now and a transfer coincide, shadow takes the old hold contents and hold takes the new data, ending full.
  - in_data is ignored unless a transfer occurs; no data is lost or duplicated.
- Latency: a pair accepted at cnt=c<255 starts serialising at the next cnt=0. Its MSB appears on sdin_dac over cnt=4..7.
- Throughput: at most 1 pair per 256 clk; upstream stalls on in_ready=0.
- Reset mid-frame: stream restarts at cnt=0 with zero shadow; any pending hold data is discarded.

Decomposition:
- Package audio_pkg holds SAMPLE_W=24, FRAME_MCLK=256, SCLK_DIV=4, SLOT_BITS=32, LEFT_LRCK=1'b0. The capture stage shares these constants.
- Sub-module i2s_clkgen holds cnt and produces lrck, sclk, bit position, load strobe (cnt==255) and sdin update strobe. It is reusable by the capture stage.

Test Plan:
- Assert rst for 3 clk mid-count.
  -> sdin_dac=0, lrck_dac=0, sclk_dac=0, underrun_cnt=0 and in_ready=1 after release; cnt restarts at 0.
- Write L=0xA5A5A5, R=0x5A5A5A at cnt=10.
  -> in_ready=0 until cnt=255.
  -> Next frame: sdin_dac is 0 at k=0, then 1,0,1,0,0,1,0,1,... for k=1..24, then 0 for k=25..31 (left).
  -> Right slot (cnt=128..255) carries 0,1,0,1,1,0,1,0,... for k=1..24.
- No writes for 3 frames after one pair.
  -> underrun pulses at cnt=255 of frames 2 and 3, underrun_cnt=2, the same pair is repeated on sdin_dac.
- Hold full, in_valid=1 with 0x123456/0x654321 held from cnt=200.
  -> Accepted exactly at cnt=255 (in_ready=1 only there).
  -> Old pair is serialised this frame, new pair the next; no underrun.
- mute=1 with hold full: next frame sdin_dac=0 for all k, hold empties, underrun stays 0.
- Force 2^16+5 underruns: underrun_cnt saturates at 0xFFFF.
